// File: rtl/pe_tile_engine.sv
// Tile dot-product engine: accumulates ROWS dot products over up to MAX_TILES input beats, then presents them.
// Latency: one beat per cycle, result valid the cycle after the last beat; done pulses after the output handshake.
// Backpressure: in_ready only while accumulating; the result holds stable until out_ready.
module pe_tile_engine #(
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUTPUT_WIDTH = 32,
    parameter int ROWS         = 32,
    parameter int COLS         = 8,
    parameter int MAX_TILES    = 16,
    localparam int CNT_W       = $clog2(MAX_TILES + 1)
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             abort,
    input  logic [CNT_W-1:0]                                 cfg_num_tiles,
    input  logic                                             cfg_signed,
    input  logic                                             cfg_relu,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [COLS-1:0][INPUT_WIDTH-1:0]                 in_vector,
    input  logic [ROWS-1:0][COLS-1:0][WEIGHT_WIDTH-1:0]      in_weights,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [ROWS-1:0][OUTPUT_WIDTH-1:0]                out_vector,
    output logic                                             busy,
    output logic                                             done
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    localparam int PROD_W = INPUT_WIDTH + WEIGHT_WIDTH + 2;
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_TILES);

    state_t                              r_state;
    logic [ROWS-1:0][OUTPUT_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]                    r_cnt;
    logic [CNT_W-1:0]                    r_tiles;
    logic                                r_signed;
    logic                                r_relu;
    logic                                r_done;

    logic [ROWS-1:0][OUTPUT_WIDTH-1:0]   w_dot;
    logic signed [PROD_W-1:0]            w_prod;
    logic [CNT_W-1:0]                    w_tiles;
    logic                                w_last;

    // Each operand gets one extra top bit: a copy of its MSB in signed mode, zero otherwise,
    // so a single signed multiplier serves both modes.
    always_comb begin
        w_dot  = '0;
        w_prod = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_prod = PROD_W'($signed({r_signed & in_vector[c][INPUT_WIDTH-1], in_vector[c]}))
                       * PROD_W'($signed({r_signed & in_weights[r][c][WEIGHT_WIDTH-1], in_weights[r][c]}));
                w_dot[r] = w_dot[r] + OUTPUT_WIDTH'(w_prod);
            end
        end
    end

    assign w_tiles = (cfg_num_tiles == '0)   ? CNT_W'(1) :
                     (cfg_num_tiles > MAX_T) ? MAX_T     : cfg_num_tiles;
    assign w_last  = (r_cnt == r_tiles - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_tiles  <= '0;
            r_signed <= 1'b0;
            r_relu   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_tiles  <= w_tiles;
                        r_signed <= cfg_signed;
                        r_relu   <= cfg_relu;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (in_valid) begin
                        for (int r = 0; r < ROWS; r++) begin
                            r_acc[r] <= r_acc[r] + w_dot[r];
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (out_ready) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == OUTPUT);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

    // ReLU only clamps negative sums, which exist only for two's-complement operands.
    always_comb begin
        out_vector = '0;
        for (int r = 0; r < ROWS; r++) begin
            out_vector[r] = (r_relu && r_signed && r_acc[r][OUTPUT_WIDTH-1]) ? '0 : r_acc[r];
        end
    end
endmodule

// File: tb/tb_pe_tile_engine.sv
// Randomized scoreboard bench for pe_tile_engine: a driver feeds jobs and queues expected results,
// a monitor compares every presented result and the done pulse.
module tb_pe_tile_engine;
    localparam int IW = 8, WW = 8, OW = 32, ROWS = 32, COLS = 8, MAXT = 16, CNT_W = 5;

    typedef logic [ROWS-1:0][OW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, cfg_signed, cfg_relu;
    logic in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [CNT_W-1:0] cfg_num_tiles;
    logic [COLS-1:0][IW-1:0] in_vector;
    logic [ROWS-1:0][COLS-1:0][WW-1:0] in_weights;
    vec_t out_vector;

    int checks = 0;
    int failures = 0;
    vec_t q_exp[$];
    int unsigned m_acc[ROWS];
    bit m_sgn, m_relu;

    pe_tile_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_num_tiles(cfg_num_tiles), .cfg_signed(cfg_signed), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector), .in_weights(in_weights),
        .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string nm, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int r = 0; r < ROWS; r++) begin
                if (act[r] !== exp[r]) begin
                    $display("FAIL %s row=%0d actual=%h required=%h t=%0t", nm, r, act[r], exp[r], $time);
                    break;
                end
            end
        end
    endtask

    function automatic vec_t postop();
        vec_t v;
        for (int r = 0; r < ROWS; r++) begin
            v[r] = (m_relu && m_sgn && int'(m_acc[r]) < 0) ? 32'd0 : m_acc[r];
        end
        return v;
    endfunction

    task automatic model_beat();
        for (int r = 0; r < ROWS; r++) begin
            int unsigned s = 0;
            for (int c = 0; c < COLS; c++) begin
                int p;
                if (m_sgn) p = int'($signed(in_vector[c])) * int'($signed(in_weights[r][c]));
                else       p = int'(in_vector[c]) * int'(in_weights[r][c]);
                s += unsigned'(p);
            end
            m_acc[r] += s;
        end
    endtask

    task automatic rand_data(input bit fixed, input logic [7:0] v, input logic [7:0] w);
        for (int c = 0; c < COLS; c++) in_vector[c] = fixed ? v : 8'($urandom);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) in_weights[r][c] = fixed ? w : 8'($urandom);
    endtask

    task automatic reset_check(input string tag);
        check_bit({tag, "_in_ready"}, in_ready, 0);
        check_bit({tag, "_out_valid"}, out_valid, 0);
        check_bit({tag, "_busy"}, busy, 0);
        check_bit({tag, "_done"}, done, 0);
        check_vec({tag, "_out_vector"}, out_vector, '0);
    endtask

    task automatic run_job(input logic [CNT_W-1:0] ntiles, input bit sgn, input bit relu, input bit gaps,
                           input int hold, input int abort_at, input bit fixed,
                           input logic [7:0] v, input logic [7:0] w, input bit start_in_out);
        int tiles, beats, cyc;
        tiles = (ntiles == 0) ? 1 : ((int'(ntiles) > MAXT) ? MAXT : int'(ntiles));
        start = 1'b1; cfg_num_tiles = ntiles; cfg_signed = sgn; cfg_relu = relu; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cfg_num_tiles = 5'($urandom); cfg_signed = 1'($urandom); cfg_relu = 1'($urandom);
        m_sgn = sgn; m_relu = relu;
        for (int r = 0; r < ROWS; r++) m_acc[r] = 0;
        check_bit("busy_after_start", busy, 1);
        beats = 0; cyc = 0;
        while (beats < tiles) begin
            if (beats == abort_at) begin
                abort = 1'b1; in_valid = 1'b1; start = 1'b1; rand_data(1'b0, 8'd0, 8'd0);
                @(negedge clk);
                abort = 1'b0; in_valid = 1'b0; start = 1'b0;
                check_bit("abort_busy", busy, 0);
                check_bit("abort_in_ready", in_ready, 0);
                check_vec("abort_hold", out_vector, postop());
                @(negedge clk);
                check_bit("abort_idle_busy", busy, 0);
                return;
            end
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            rand_data(fixed, v, w);
            check_bit("in_ready", in_ready, 1);
            if (in_valid) begin
                model_beat();
                beats++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_bit("last_in_ready", in_ready, 0);
        check_bit("out_valid_after_last", out_valid, 1);
        q_exp.push_back(postop());
        repeat (hold) begin
            start = start_in_out; in_valid = 1'b1; rand_data(1'b0, 8'd0, 8'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; start = start_in_out;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check_bit("idle_busy", busy, 0);
        check_bit("idle_out_valid", out_valid, 0);
        @(negedge clk);
        check_vec("idle_hold", out_vector, postop());
        check_bit("idle_busy2", busy, 0);
    endtask

    // Scoreboard monitor: samples just after the driver has settled the falling-edge inputs.
    initial begin
        bit pend, e;
        pend = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                pend = 0;
                continue;
            end
            e = pend;
            pend = 0;
            if (done || e) check_bit("done_pulse", done, e);
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_unexpected actual=out_valid required=no_result t=%0t", $time);
                end else if (out_ready) begin
                    check_vec("out_vector", out_vector, q_exp.pop_front());
                    pend = 1;
                end else begin
                    check_vec("out_stable", out_vector, q_exp[0]);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_tiles = '0; cfg_signed = 1'b0; cfg_relu = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_vector = '0; in_weights = '0;
        repeat (3) @(negedge clk);
        reset_check("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(5'd1, 1'b0, 1'b0, 1'b0, 0, -1, 1'b1, 8'd2, 8'd3, 1'b0);
        check_bit("single_beat_row0", out_vector[0], 32'd48);
        run_job(5'd4, 1'b1, 1'b0, 1'b0, 0, -1, 1'b1, 8'hFF, 8'd5, 1'b0);
        check_bit("signed_row0", out_vector[0], 32'hFFFF_FF60);
        run_job(5'd4, 1'b1, 1'b1, 1'b0, 0, -1, 1'b1, 8'hFF, 8'd5, 1'b0);
        check_bit("relu_row0", out_vector[0], 32'd0);
        run_job(5'd4, 1'b0, 1'b1, 1'b0, 0, -1, 1'b1, 8'hFF, 8'd5, 1'b0);
        run_job(5'd6, 1'b1, 1'b0, 1'b1, 5, -1, 1'b0, 8'd0, 8'd0, 1'b0);
        run_job(5'd4, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 8'd0, 8'd0, 1'b0);
        run_job(5'd0, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0, 8'd0, 8'd0, 1'b0);
        run_job(5'd31, 1'b1, 1'b1, 1'b1, 0, -1, 1'b0, 8'd0, 8'd0, 1'b0);
        run_job(5'd3, 1'b0, 1'b0, 1'b0, 3, -1, 1'b0, 8'd0, 8'd0, 1'b1);
        run_job(5'd2, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 8'd0, 8'd0, 1'b1);

        // Reset in the middle of accumulation.
        start = 1'b1; cfg_num_tiles = 5'd4; cfg_signed = 1'b1; cfg_relu = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1; rand_data(1'b0, 8'd0, 8'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        reset_check("mid_reset");
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_bit("post_reset_busy", busy, 0);
        check_bit("post_reset_done", done, 0);

        for (int j = 0; j < 25; j++) begin
            run_job(5'($urandom_range(0, 20)), 1'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
                    1'b0, 8'd0, 8'd0, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check_bit("queue_drained", 32'(q_exp.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
